// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the unified-memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   REQ_IF/REQ_D: requester identifiers used for the winner and last-granted pointer
//   CNT_W       : width of the memory-latency wait counter (MEM_LAT up to 15)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick
// Combinational winner selection between the fetch and data requesters.
// Optional feature macro: ARB_RR_EN (round-robin on conflict using i_last).
// Ports:
//   i_if_req  : fetch request level
//   i_d_req   : data request level
//   i_last    : last-granted requester (only present with ARB_RR_EN)
//   o_valid   : at least one request is pending
//   o_winner  : REQ_IF or REQ_D, meaningful only when o_valid is high
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_if_req,
    input  logic i_d_req,
`ifdef ARB_RR_EN
    input  logic i_last,
`endif
    output logic o_valid,
    output logic o_winner
);

    // On a conflict the round-robin build hands the grant to whichever
    // requester was not served last; the default build always favours data.
    always_comb begin
        o_valid  = i_if_req | i_d_req;
        o_winner = REQ_IF;
        if (i_if_req && i_d_req) begin
`ifdef ARB_RR_EN
            o_winner = (i_last == REQ_D) ? REQ_IF : REQ_D;
`else
            o_winner = REQ_D;
`endif
        end else if (i_d_req) begin
            o_winner = REQ_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Lets the instruction-fetch and data requesters share one single-ported,
// fixed-latency unified memory, one access at a time.
// Optional feature macro: ARB_RR_EN (round-robin arbitration on conflict;
// when undefined, data has fixed priority and no pointer exists).
// Parameters: AW address width, DW data width, MEM_LAT memory latency (1..15).
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   if_req/if_addr                 : fetch request and address
//   if_gnt/if_rdata/if_rvalid      : fetch accept pulse, read data, completion pulse
//   d_req/d_we/d_be/d_addr/d_wdata : data request, write enable, byte enables, address, write data
//   d_gnt/d_rdata/d_rvalid         : data accept pulse, read data, completion pulse
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata : memory strobe and access fields
//   mem_rdata                      : memory read data, valid on the last WAIT cycle
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic [DW-1:0]   if_rdata,
    output logic            if_rvalid,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic [DW-1:0]   d_rdata,
    output logic            d_rvalid,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_winner;
    logic             r_mem_we;
    logic [DW/8-1:0]  r_mem_be;
    logic [AW-1:0]    r_mem_addr;
    logic [DW-1:0]    r_mem_wdata;
    logic [DW-1:0]    r_if_rdata;
    logic [DW-1:0]    r_d_rdata;
    logic             w_valid;
    logic             w_winner;
    logic             w_take;
    logic             w_capture;
`ifdef ARB_RR_EN
    logic             r_last;
`endif

    arb_pick u_pick (
        .i_if_req (if_req),
        .i_d_req  (d_req),
`ifdef ARB_RR_EN
        .i_last   (r_last),
`endif
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and decoded outputs. Grant and memory strobe share the ISSUE
    // cycle, so gnt and rvalid can never overlap and only the winner sees them.
    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_capture    = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        if_gnt       = 1'b0;
        d_gnt        = 1'b0;
        if_rvalid    = 1'b0;
        d_rvalid     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_take       = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                mem_en       = 1'b1;
                mem_we       = r_mem_we;
                if_gnt       = (r_winner == REQ_IF);
                d_gnt        = (r_winner == REQ_D);
                w_next_state = WAIT;
            end
            WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_capture    = !r_mem_we;
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if_rvalid    = (r_winner == REQ_IF);
                d_rvalid     = (r_winner == REQ_D);
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Latency counter: loaded while the strobe is out, so WAIT spans exactly
    // MEM_LAT cycles and its final cycle is the one with valid mem_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_cnt <= CNT_W'(MEM_LAT);
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Access fields are captured once at acceptance and held until the next
    // grant, which keeps them stable from ISSUE through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_winner    <= REQ_IF;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_take) begin
            r_winner <= w_winner;
            if (w_winner == REQ_D) begin
                r_mem_we    <= d_we;
                r_mem_be    <= d_be;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
            end else begin
                r_mem_we    <= 1'b0;
                r_mem_be    <= '1;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
            end
        end
    end

    // Read data lands only in the winner's register; writes leave both alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else if (w_capture) begin
            if (r_winner == REQ_D) begin
                r_d_rdata <= mem_rdata;
            end else begin
                r_if_rdata <= mem_rdata;
            end
        end
    end

`ifdef ARB_RR_EN
    // Last-granted pointer; resets to "fetch last" so data wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= REQ_IF;
        end else if (w_take) begin
            r_last <= w_winner;
        end
    end
`endif

    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Bench for mem_arbiter. Two instances share the same request inputs:
// dut0 with MEM_LAT=2 and dut1 with MEM_LAT=1, each with its own
// fixed-latency memory model that returns the word only on the valid cycle.
// Honours ARB_RR_EN for the held-conflict grant order.
module tb_mem_arbiter;

    typedef struct {
        logic        isData;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memData;
        logic [31:0] expIfRdata;
        logic [31:0] expDRdata;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic        ifGnt0, ifRvalid0, dGnt0, dRvalid0, memEn0, memWe0;
    logic [3:0]  memBe0;
    logic [31:0] memAddr0, memWdata0, ifRdata0, dRdata0, memRdata0;
    logic        ifGnt1, ifRvalid1, dGnt1, dRvalid1, memEn1, memWe1;
    logic [3:0]  memBe1;
    logic [31:0] memAddr1, memWdata1, ifRdata1, dRdata1, memRdata1;

    logic        selLat1;
    logic [31:0] tbMemData;
    int          rem0, rem1;
    int          total, bad;

    logic        oIfGnt, oIfRvalid, oDGnt, oDRvalid, oMemEn, oMemWe;
    logic [3:0]  oMemBe;
    logic [31:0] oMemAddr, oMemWdata, oIfRdata, oDRdata;

    vec_t        vecs[6];
    int          dG, iG, nG, quiet;
    logic        dDone, iDone;
    int          gCyc[4];
    logic        gWho[4];
    logic        expWho;

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(ifGnt0), .if_rdata(ifRdata0), .if_rvalid(ifRvalid0),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(dGnt0), .d_rdata(dRdata0), .d_rvalid(dRvalid0),
        .mem_en(memEn0), .mem_we(memWe0), .mem_be(memBe0), .mem_addr(memAddr0),
        .mem_wdata(memWdata0), .mem_rdata(memRdata0)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(ifGnt1), .if_rdata(ifRdata1), .if_rvalid(ifRvalid1),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(dGnt1), .d_rdata(dRdata1), .d_rvalid(dRvalid1),
        .mem_en(memEn1), .mem_we(memWe1), .mem_be(memBe1), .mem_addr(memAddr1),
        .mem_wdata(memWdata1), .mem_rdata(memRdata1)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: the word is presented only on the MEM_LAT-th cycle after
    // the strobe, anything else reads as a recognisable junk pattern.
    always @(posedge clk) begin
        if (memEn0) rem0 <= 2;
        else if (rem0 != 0) rem0 <= rem0 - 1;
        if (memEn1) rem1 <= 1;
        else if (rem1 != 0) rem1 <= rem1 - 1;
    end
    assign memRdata0 = (rem0 == 1) ? tbMemData : 32'hBADBAD00;
    assign memRdata1 = (rem1 == 1) ? tbMemData : 32'hBADBAD00;

    // Observed instance selection.
    assign oIfGnt    = selLat1 ? ifGnt1    : ifGnt0;
    assign oIfRvalid = selLat1 ? ifRvalid1 : ifRvalid0;
    assign oDGnt     = selLat1 ? dGnt1     : dGnt0;
    assign oDRvalid  = selLat1 ? dRvalid1  : dRvalid0;
    assign oMemEn    = selLat1 ? memEn1    : memEn0;
    assign oMemWe    = selLat1 ? memWe1    : memWe0;
    assign oMemBe    = selLat1 ? memBe1    : memBe0;
    assign oMemAddr  = selLat1 ? memAddr1  : memAddr0;
    assign oMemWdata = selLat1 ? memWdata1 : memWdata0;
    assign oIfRdata  = selLat1 ? ifRdata1  : ifRdata0;
    assign oDRdata   = selLat1 ? dRdata1   : dRdata0;

    task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
        end
    endtask

    task checkAllZero(input string tag);
        checkOutput({tag, "/ctrl"}, {26'd0, oIfGnt, oIfRvalid, oDGnt, oDRvalid, oMemEn, oMemWe}, 32'd0);
        checkOutput({tag, "/memBe"}, {28'd0, oMemBe}, 32'd0);
        checkOutput({tag, "/memAddr"}, oMemAddr, 32'd0);
        checkOutput({tag, "/memWdata"}, oMemWdata, 32'd0);
        checkOutput({tag, "/ifRdata"}, oIfRdata, 32'd0);
        checkOutput({tag, "/dRdata"}, oDRdata, 32'd0);
    endtask

    // One access from cycle 0 (request raised), request dropped in cycle 2,
    // observed for a bounded window on the selected instance.
    task automatic applyStimulus(input vec_t v, input string tag);
        int          lat, gntCyc, enCyc, enCount, rvCyc, rvCount, wrongSide, unstable;
        logic [31:0] addrAtEn, wdataAtEn, ifRdAtRv, dRdAtRv;
        logic [3:0]  beAtEn;
        logic        weAtEn, myGnt, myRv, otherGnt, otherRv;
        lat = selLat1 ? 1 : 2;
        gntCyc = -1; enCyc = -1; enCount = 0; rvCyc = -1; rvCount = 0;
        wrongSide = 0; unstable = 0;
        addrAtEn = '0; wdataAtEn = '0; ifRdAtRv = '0; dRdAtRv = '0; beAtEn = '0; weAtEn = 1'b0;
        tbMemData = v.memData;
        if (v.isData) begin
            d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            myGnt    = v.isData ? oDGnt    : oIfGnt;
            otherGnt = v.isData ? oIfGnt   : oDGnt;
            myRv     = v.isData ? oDRvalid : oIfRvalid;
            otherRv  = v.isData ? oIfRvalid : oDRvalid;
            if (otherGnt || otherRv || (myGnt && myRv)) wrongSide++;
            if (myGnt && gntCyc < 0) gntCyc = cyc;
            if (oMemEn) begin
                enCount++;
                if (enCyc < 0) begin
                    enCyc = cyc; addrAtEn = oMemAddr; wdataAtEn = oMemWdata;
                    beAtEn = oMemBe; weAtEn = oMemWe;
                end
            end else if (enCyc >= 0 && rvCyc < 0) begin
                if (oMemAddr !== addrAtEn || oMemBe !== beAtEn || oMemWdata !== wdataAtEn) unstable++;
            end
            if (myRv) begin
                rvCount++;
                if (rvCyc < 0) begin
                    rvCyc = cyc; ifRdAtRv = oIfRdata; dRdAtRv = oDRdata;
                end
            end
            @(posedge clk); #1;
            if (cyc == 1) begin
                if_req = 1'b0; d_req = 1'b0;
            end
        end
        checkOutput({tag, "/gntCycle"}, gntCyc, 32'd1);
        checkOutput({tag, "/enCycle"}, enCyc, 32'd1);
        checkOutput({tag, "/enCount"}, enCount, 32'd1);
        checkOutput({tag, "/rvalidCycle"}, rvCyc, 2 + lat);
        checkOutput({tag, "/rvalidCount"}, rvCount, 32'd1);
        checkOutput({tag, "/memAddr"}, addrAtEn, v.addr);
        checkOutput({tag, "/memWe"}, {31'd0, weAtEn}, {31'd0, v.isData & v.we});
        checkOutput({tag, "/memBe"}, {28'd0, beAtEn}, {28'd0, (v.isData ? v.be : 4'hF)});
        if (v.isData) checkOutput({tag, "/memWdata"}, wdataAtEn, v.wdata);
        checkOutput({tag, "/ifRdata"}, ifRdAtRv, v.expIfRdata);
        checkOutput({tag, "/dRdata"}, dRdAtRv, v.expDRdata);
        checkOutput({tag, "/wrongSide"}, wrongSide, 32'd0);
        checkOutput({tag, "/unstable"}, unstable, 32'd0);
    endtask

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        total = 0; bad = 0; rem0 = 0; rem1 = 0;
        rst_n = 1'b0; selLat1 = 1'b0; tbMemData = 32'h0;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;

        //                 isData we  be     addr          wdata         memData       expIf         expD
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h00400000, 32'h00000000, 32'h20080005, 32'h20080005, 32'h00000000};
        vecs[1] = '{1'b1, 1'b1, 4'hF, 32'h10010000, 32'hDEADBEEF, 32'h99999999, 32'h20080005, 32'h00000000};
        vecs[2] = '{1'b1, 1'b0, 4'h3, 32'h10010004, 32'h00000000, 32'h12345678, 32'h20080005, 32'h12345678};
        vecs[3] = '{1'b1, 1'b1, 4'h5, 32'h10010008, 32'hCAFEF00D, 32'h77777777, 32'h20080005, 32'h12345678};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h00400004, 32'h00000000, 32'h8C090000, 32'h8C090000, 32'h12345678};
        vecs[5] = '{1'b1, 1'b0, 4'hF, 32'h10010008, 32'h00000000, 32'hA5A5A5A5, 32'h8C090000, 32'hA5A5A5A5};

        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset0");
        selLat1 = 1'b1;
        #1;
        checkAllZero("reset1");
        selLat1 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Conflict: both raised in cycle 0, each drops after its own rvalid.
        $display("[TB] conflict, requests released after completion");
        dG = -1; iG = -1; dDone = 1'b0; iDone = 1'b0;
        if_req = 1'b1; if_addr = 32'h00400008;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h10010010;
        for (int cyc = 0; cyc < 17; cyc++) begin
            @(negedge clk);
            if (oDGnt && dG < 0) dG = cyc;
            if (oIfGnt && iG < 0) iG = cyc;
            if (oDRvalid) dDone = 1'b1;
            if (oIfRvalid) iDone = 1'b1;
            @(posedge clk); #1;
            if (dDone) d_req = 1'b0;
            if (iDone) if_req = 1'b0;
        end
        checkOutput("conflictA/dataGnt", dG, 32'd1);
        checkOutput("conflictA/fetchGnt", iG, 32'd6);
        repeat (6) @(posedge clk);
        #1;

        // Conflict with both requests held for four grants.
        $display("[TB] conflict, requests held");
        nG = 0;
        for (int k = 0; k < 4; k++) begin
            gCyc[k] = -1; gWho[k] = 1'b0;
        end
        if_req = 1'b1; d_req = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if ((oIfGnt || oDGnt) && nG < 4) begin
                gCyc[nG] = cyc; gWho[nG] = oDGnt; nG++;
            end
            @(posedge clk); #1;
            if (nG == 4) begin
                if_req = 1'b0; d_req = 1'b0;
            end
        end
        checkOutput("conflictB/grants", nG, 32'd4);
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            expWho = (k % 2 == 0);
`else
            expWho = 1'b1;
`endif
            checkOutput($sformatf("conflictB/gntCycle%0d", k), gCyc[k], 1 + 5 * k);
            checkOutput($sformatf("conflictB/gntIsData%0d", k), {31'd0, gWho[k]}, {31'd0, expWho});
        end
        repeat (8) @(posedge clk);
        #1;

        // Single accesses from the table.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted during WAIT of a data read.
        $display("[TB] reset during access");
        tbMemData = 32'h3C3C3C3C;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h1001000C;
        @(posedge clk); #1;
        @(posedge clk); #1;
        d_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("rstMid0");
        selLat1 = 1'b1;
        #1;
        checkAllZero("rstMid1");
        selLat1 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        quiet = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (oIfGnt || oDGnt || oIfRvalid || oDRvalid || oMemEn) quiet++;
            @(posedge clk); #1;
        end
        checkOutput("rstMid/noActivity", quiet, 32'd0);
        checkOutput("rstMid/dRdataAfter", oDRdata, 32'd0);
        applyStimulus('{1'b1, 1'b0, 4'hF, 32'h10010014, 32'h0, 32'h55AA33CC, 32'h0, 32'h55AA33CC}, "afterRst");

        // Latency boundary on the MEM_LAT=1 instance.
        $display("[TB] latency boundary");
        selLat1 = 1'b1;
        #1;
        applyStimulus('{1'b0, 1'b0, 4'h0, 32'h00400010, 32'h0, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h55AA33CC}, "lat1Fetch");
        applyStimulus('{1'b1, 1'b0, 4'hF, 32'h10010020, 32'h0, 32'h76543210, 32'h0F0F0F0F, 32'h76543210}, "lat1Read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
